// File: rtl/counter_job_scheduler.sv
// rtl/counter_job_scheduler.sv - round-robin scheduler sharing one up/down counter among requesters
module counter_job_scheduler #(
    parameter int NREQ   = 4,
    parameter int STEP_W = 4,
    parameter int CNT_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_dir,
    input  logic [NREQ*STEP_W-1:0]   req_steps,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [NREQ-1:0]          err,
    output logic [CNT_W-1:0]         result,
    output logic                     busy,
    output logic                     cnt_reset,
    output logic                     cnt_act,
    output logic                     cnt_up_down,
    input  logic                     cnt_overflow,
    input  logic [CNT_W-1:0]         cnt_value
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FIN   = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    logic [2:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  idx;
    logic              dir;
    logic [STEP_W-1:0] rem;
    logic [CNT_W-1:0]  result_q;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  next_ptr;
    logic [NREQ-1:0]   idx_oh;

    // Round-robin search: first requester at or after ptr, wrapping around
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NREQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign next_ptr = (idx == IDX_W'(NREQ - 1)) ? '0 : idx + 1'b1;
    assign idx_oh   = NREQ'(1) << idx;

    // Job sequencing: latch a job in IDLE, clear, step the counter, then report
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            idx      <= '0;
            dir      <= 1'b0;
            rem      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        idx   <= pick_idx;
                        dir   <= req_dir[pick_idx];
                        rem   <= req_steps[int'(pick_idx)*STEP_W +: STEP_W];
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= (rem == '0) ? S_FIN : S_RUN;
                end
                S_RUN: begin
                    rem <= rem - 1'b1;
                    if (cnt_overflow) begin
                        state <= S_ABORT;
                    end else if (rem == STEP_W'(1)) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    result_q <= cnt_value;
                    ptr      <= next_ptr;
                    state    <= S_IDLE;
                end
                S_ABORT: begin
                    ptr   <= next_ptr;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode of the state; result tracks the counter during FIN so it is
    // valid alongside done, and holds its last completed value otherwise
    always_comb begin
        gnt         = '0;
        done        = '0;
        err         = '0;
        busy        = (state != S_IDLE);
        cnt_reset   = (state == S_LOAD) || (state == S_ABORT);
        cnt_act     = (state == S_RUN);
        cnt_up_down = (state == S_RUN) && dir;
        result      = (state == S_FIN) ? cnt_value : result_q;
        if ((state == S_LOAD) || (state == S_RUN) || (state == S_FIN) || (state == S_ABORT)) begin
            gnt = idx_oh;
        end
        if (state == S_FIN) begin
            done = idx_oh;
        end
        if (state == S_ABORT) begin
            err = idx_oh;
        end
    end

endmodule

// File: tb/tb_counter_job_scheduler.sv
// tb/tb_counter_job_scheduler.sv - self-checking bench for counter_job_scheduler
module tb_counter_job_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_dir;
    logic [15:0] req_steps;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic [3:0]  result;
    logic        busy;
    logic        cnt_reset;
    logic        cnt_act;
    logic        cnt_up_down;
    logic        ovf;
    logic [3:0]  cnt_q;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    counter_job_scheduler #(.NREQ(4), .STEP_W(4), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_dir      (req_dir),
        .req_steps    (req_steps),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .result       (result),
        .busy         (busy),
        .cnt_reset    (cnt_reset),
        .cnt_act      (cnt_act),
        .cnt_up_down  (cnt_up_down),
        .cnt_overflow (ovf),
        .cnt_value    (cnt_q)
    );

    always #5 clk = ~clk;

    // External counter shared by all jobs
    always @(posedge clk) begin
        if (reset || cnt_reset) cnt_q <= 4'd0;
        else if (cnt_act) cnt_q <= cnt_up_down ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Job-level model: t counts cycles since the request was sampled
    bit m_active = 1'b0;
    bit m_abort  = 1'b0;
    bit m_dir    = 1'b0;
    int m_t = 0, m_idx = 0, m_steps = 0, m_ptr = 0, m_hold = 0;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    function automatic int model_res();
        return (m_dir ? m_steps : 16 - m_steps) & 15;
    endfunction

    function automatic bit in_act();
        return m_active && !m_abort && m_t >= 2 && m_t <= m_steps + 1;
    endfunction

    function automatic bit in_fin();
        return m_active && !m_abort && m_t == m_steps + 2;
    endfunction

    function automatic logic [3:0] exp_gnt();
        return m_active ? 4'(1 << m_idx) : 4'd0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0; m_abort <= 1'b0; m_ptr <= 0; m_hold <= 0;
        end else if (!m_active) begin
            if (req != 4'd0) begin
                m_active <= 1'b1;
                m_abort  <= 1'b0;
                m_t      <= 1;
                m_idx    <= pick(req, m_ptr);
                m_dir    <= req_dir[pick(req, m_ptr)];
                m_steps  <= int'(req_steps[pick(req, m_ptr)*4 +: 4]);
            end
        end else if (m_abort) begin
            m_active <= 1'b0; m_abort <= 1'b0; m_ptr <= (m_idx + 1) % 4;
        end else if (in_act() && ovf) begin
            m_abort <= 1'b1;
        end else if (in_fin()) begin
            m_active <= 1'b0; m_ptr <= (m_idx + 1) % 4; m_hold <= model_res();
        end else begin
            m_t <= m_t + 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_gnt", gnt, exp_gnt());
            chk("m_busy", busy, m_active);
            chk("m_cnt_reset", cnt_reset, m_active && (m_abort || m_t == 1));
            chk("m_cnt_act", cnt_act, in_act());
            chk("m_up_down", cnt_up_down, in_act() && m_dir);
            chk("m_done", done, in_fin() ? exp_gnt() : 4'd0);
            chk("m_err", err, (m_active && m_abort) ? exp_gnt() : 4'd0);
            chk("m_result", result, in_fin() ? model_res() : m_hold);
        end
    end

    // Grant order and grant length recorder
    logic [3:0] prev_gnt = 4'd0;
    int cur_len = 0;
    int gseq[$];
    int glen[$];

    function automatic int oh2i(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v[k]) return k;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (gnt != 4'd0) begin
                if (prev_gnt == 4'd0) begin
                    gseq.push_back(oh2i(gnt));
                    cur_len <= 1;
                end else begin
                    cur_len <= cur_len + 1;
                end
            end else if (prev_gnt != 4'd0) begin
                glen.push_back(cur_len);
            end
            prev_gnt <= gnt;
        end
    end

    task automatic nc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_job(input int i, input logic d, input logic [3:0] s);
        req_dir[i] = d;
        req_steps[i*4 +: 4] = s;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        nc(1);
        while (busy && n < 100) begin
            nc(1);
            n++;
        end
        chk("idle_bound", n < 100, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int exp_seq[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b1; req = 4'd0; req_dir = 4'd0; req_steps = 16'd0; ovf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_act", cnt_act, 0);
        chk("rst_cnt_reset", cnt_reset, 0);

        // All four requesting, one step each: strict rotation from ptr=0
        for (int i = 0; i < 4; i++) set_job(i, 1'b1, 4'd1);
        gseq.delete();
        glen.delete();
        req = 4'hF;
        nc(22);
        req = 4'd0;
        wait_idle();
        chk("t2_njobs", (gseq.size() >= 5) && (glen.size() >= 5), 1);
        if (gseq.size() >= 5 && glen.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("t2_order", gseq[k], exp_seq[k]);
                chk("t2_len", glen[k], 3);
            end
        end

        // Single up job of 5 steps
        set_job(0, 1'b1, 4'd5);
        req = 4'b0001;
        nc(1);
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_cnt_reset", cnt_reset, 1);
        req = 4'd0;
        for (int k = 0; k < 5; k++) begin
            nc(1);
            chk("t1_act", cnt_act, 1);
            chk("t1_dir", cnt_up_down, 1);
        end
        nc(1);
        chk("t1_done", done, 4'b0001);
        chk("t1_result", result, 5);
        chk("t1_act_off", cnt_act, 0);
        wait_idle();

        // Zero-step job: clear only
        set_job(2, 1'b1, 4'd0);
        req = 4'b0100;
        nc(1);
        chk("t3_gnt", gnt, 4'b0100);
        chk("t3_cnt_reset", cnt_reset, 1);
        chk("t3_act", cnt_act, 0);
        req = 4'd0;
        nc(1);
        chk("t3_done", done, 4'b0100);
        chk("t3_result", result, 0);
        chk("t3_act2", cnt_act, 0);
        wait_idle();

        // Overflow on the third RUN cycle aborts; ptr moves to 2
        set_job(1, 1'b1, 4'd15);
        req = 4'b0010;
        nc(1);
        chk("t4_gnt", gnt, 4'b0010);
        req = 4'd0;
        nc(3);
        ovf = 1'b1;
        nc(1);
        ovf = 1'b0;
        chk("t4_err", err, 4'b0010);
        chk("t4_cnt_reset", cnt_reset, 1);
        chk("t4_no_done", done, 0);
        chk("t4_act", cnt_act, 0);
        nc(1);
        chk("t4_idle", busy, 0);
        set_job(1, 1'b1, 4'd1);
        set_job(3, 1'b1, 4'd1);
        req = 4'b1010;
        nc(1);
        chk("t4_ptr", gnt, 4'b1000);
        req = 4'd0;
        wait_idle();

        // Reset in the second RUN cycle drops the job; ptr returns to 0
        set_job(2, 1'b1, 4'd8);
        req = 4'b0100;
        nc(1);
        chk("t5_gnt", gnt, 4'b0100);
        req = 4'd0;
        nc(2);
        reset = 1'b1;
        nc(1);
        chk("t5_gnt0", gnt, 0);
        chk("t5_busy0", busy, 0);
        chk("t5_done0", done, 0);
        chk("t5_err0", err, 0);
        chk("t5_act0", cnt_act, 0);
        chk("t5_result0", result, 0);
        reset = 1'b0;
        set_job(0, 1'b0, 4'd2);
        set_job(3, 1'b0, 4'd2);
        req = 4'b1001;
        nc(1);
        chk("t5_ptr0", gnt, 4'b0001);
        req = 4'b1000;
        begin
            int n;
            bit seen;
            n = 0;
            seen = 1'b0;
            while (!seen && n < 40) begin
                nc(1);
                n++;
                if (done[3]) begin
                    seen = 1'b1;
                    chk("t5_result3", result, 14);
                end
            end
            chk("t5_done3_seen", seen, 1);
        end
        req = 4'd0;
        wait_idle();

        // Request dropped and steps changed mid-RUN: latched job still completes
        set_job(0, 1'b1, 4'd4);
        req = 4'b0001;
        nc(1);
        chk("t6_gnt", gnt, 4'b0001);
        nc(2);
        req = 4'd0;
        set_job(0, 1'b0, 4'd9);
        for (int k = 0; k < 2; k++) begin
            nc(1);
            chk("t6_act", cnt_act, 1);
            chk("t6_dir", cnt_up_down, 1);
        end
        nc(1);
        chk("t6_done", done, 4'b0001);
        chk("t6_result", result, 4);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
